step_clock_ctrl: RTL and testbench

STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

---
 rtl/step_clock_ctrl_if.sv | 33 +++
 rtl/step_clock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_step_clock_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/step_clock_ctrl_if.sv
// -----------------------------------------------------------------------------
// step_clock_ctrl_if
// Signal bundle between the single-step clock controller and its environment:
// the raw button and mode switch going in, the core clock enable, step counter
// and mode indication coming out.
// The master drives the button/switch and observes the outputs; the slave is
// the controller itself.
// -----------------------------------------------------------------------------
interface step_clock_ctrl_if;

  logic       push;        // raw bouncing push-button level, 1 = pressed
  logic       ena_switch;  // raw mode switch, 0 = free-run, 1 = single-step
  logic       cpu_en;      // clock enable to the processor core
  logic [7:0] step_count;  // single-step pulses issued since reset
  logic       step_mode;   // synchronized mode switch, for LEDs

  modport master (
    output push,
    output ena_switch,
    input  cpu_en,
    input  step_count,
    input  step_mode
  );

  modport slave (
    input  push,
    input  ena_switch,
    output cpu_en,
    output step_count,
    output step_mode
  );

endinterface : step_clock_ctrl_if

// File: rtl/step_clock_ctrl.sv
// -----------------------------------------------------------------------------
// step_clock_ctrl
// Clock-enable generator that lets a processor core either free-run or advance
// one cycle per debounced push-button press.
//
//   push / ena_switch -> 2-flop synchronizers
//   synced push       -> counter debouncer (DEBOUNCE_CYCLES stable cycles)
//   debounced level   -> registered rise/fall detector
//   rise / fall       -> IDLE / PRESSED / WAIT_RELEASE press tracker
//   PRESSED           -> one-cycle cpu_en pulse when in single-step mode
//
// With a clean press the pulse appears DEBOUNCE_CYCLES+4 clocks after the first
// edge that samples push=1: 2 synchronizer stages, DEBOUNCE_CYCLES-1 counts plus
// the accept cycle, the edge-detect register, the PRESSED state and the output
// register.
//
// Build option: define STEP_COUNTER_EN to build the 8-bit wrapping step counter;
// without it step_count is tied to zero.
// -----------------------------------------------------------------------------
module step_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000  // legal range 2 .. 2^24-1
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active low
  step_clock_ctrl_if.slave bus
);

  // Terminal count of the debounce counter: the level is accepted on the cycle
  // the counter sits at this value.
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESSED      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic        push_s1_q;
  logic        push_s2_q;
  logic        ena_s1_q;
  logic        ena_s2_q;

  logic [23:0] db_cnt_q;
  logic        db_level_q;

  logic        db_prev_q;
  logic        db_rise_q;
  logic        db_fall_q;

  state_t      state_q;
  state_t      state_d;

  logic        step_pulse;
  logic        cpu_en_d;
  logic        cpu_en_q;
  logic        step_mode_q;

  // ---------------------------------------------------------------------------
  // Synchronizers: both asynchronous inputs get two flops before any use.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge, whatever the statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_s1_q <= 1'b0;
      push_s2_q <= 1'b0;
      ena_s1_q  <= 1'b0;
      ena_s2_q  <= 1'b0;
    end else begin
      push_s1_q <= bus.push;
      push_s2_q <= push_s1_q;
      ena_s1_q  <= bus.ena_switch;
      ena_s2_q  <= ena_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: count consecutive cycles the synced button disagrees with the
  // accepted level; any agreeing cycle restarts the count from zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (push_s2_q == db_level_q) begin
      db_cnt_q   <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_q <= push_s2_q;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q   <= db_cnt_q + 24'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detector: registered single-cycle rise/fall events of the debounced
  // level, so the press tracker only ever reacts to a clean transition.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_prev_q <= 1'b0;
      db_rise_q <= 1'b0;
      db_fall_q <= 1'b0;
    end else begin
      db_prev_q <= db_level_q;
      db_rise_q <= db_level_q & ~db_prev_q;
      db_fall_q <= ~db_level_q & db_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Press tracker state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press tracker next state and pulse request: one PRESSED cycle per press,
  // then wait for a debounced release before another press is recognised.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    step_pulse = 1'b0;
    cpu_en_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (db_rise_q) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (db_fall_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The pulse is judged against the mode that will be displayed alongside it,
    // so a press seen in free-run mode is simply dropped, never deferred.
    step_pulse = ena_s2_q && (state_q == PRESSED);

    // Free-run: enable every cycle. Single-step: enable only for the pulse.
    // Using the same synced switch value as step_mode makes cpu_en follow a
    // mode change on exactly the edge step_mode does.
    cpu_en_d   = ena_s2_q ? step_pulse : 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output registers: clock enable and displayed mode update together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_en_q    <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      cpu_en_q    <= cpu_en_d;
      step_mode_q <= ena_s2_q;
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.step_mode = step_mode_q;

`ifdef STEP_COUNTER_EN
  logic [7:0] step_cnt_q;

  // ---------------------------------------------------------------------------
  // Step counter: counts issued single-step pulses, wrapping 255 -> 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= 8'h00;
    end else if (step_pulse) begin
      step_cnt_q <= step_cnt_q + 8'd1;
    end
  end

  assign bus.step_count = step_cnt_q;
`else
  assign bus.step_count = 8'h00;
`endif

endmodule : step_clock_ctrl

// File: tb/tb_step_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_clock_ctrl
// Directed bench for step_clock_ctrl with DEBOUNCE_CYCLES=4. Every clean press
// in step mode pushes its expected pulse cycle and step count to a queue; a
// monitor pops and compares whenever a step-mode pulse appears, so missing,
// late, early, duplicated or spurious pulses are all caught.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ps/1ps

module tb_step_clock_ctrl;

  localparam int D   = 4;
  // From the falling edge that drives push=1, the next rising edge is the first
  // sample; the pulse is registered D+4 edges later and seen at that negedge.
  localparam int LAT = D + 5;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  int         cyc   = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_steps = 8'h00;
  exp_t       exp_q[$];

  step_clock_ctrl_if bus ();

  step_clock_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Record the pulse a clean press driven at this negedge must produce.
  task automatic expect_pulse();
    exp_t e;
`ifdef STEP_COUNTER_EN
    exp_steps = exp_steps + 8'd1;
`endif
    e.cyc = cyc + LAT;
    e.cnt = exp_steps;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    check("rst_step_count", {24'd0, bus.step_count}, 32'd0);
    check("rst_step_mode", {31'd0, bus.step_mode}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_steps = 8'h00;
  endtask

  // Scoreboard side: every step-mode pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.step_mode === 1'b1 && bus.cpu_en === 1'b1) begin
      check("pulse_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", {24'd0, bus.step_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push       = 1'b0;
    bus.ena_switch = 1'b0;
    reset          = 1'b0;

    // Power-on reset, free-run: enable low in reset, high right after.
    @(negedge clk);
    @(negedge clk);
    check("por_cpu_en_in_reset", {31'd0, bus.cpu_en}, 32'd0);
    check("por_step_count", {24'd0, bus.step_count}, 32'd0);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("por_cpu_en_after", {31'd0, bus.cpu_en}, 32'd1);
    check("por_step_mode", {31'd0, bus.step_mode}, 32'd0);
    check("por_step_count_after", {24'd0, bus.step_count}, 32'd0);

    // Clean press held 20 cycles in step mode: one pulse.
    bus.ena_switch = 1'b1;
    do_reset();
    cycles(5);
    check("step_idle_mode", {31'd0, bus.step_mode}, 32'd1);
    check("step_idle_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    bus.push = 1'b1;
    expect_pulse();
    cycles(20);
    check("clean_step_count", {24'd0, bus.step_count}, {24'd0, exp_steps});
    check("clean_queue_empty", exp_q.size(), 32'd0);
    bus.push = 1'b0;
    cycles(12);

    // Bouncing press: never stable for D cycles until it settles high.
    do_reset();
    cycles(5);
    for (int i = 0; i < 12; i++) begin
      bus.push = ((i % 4) < 2);
      cycles(1);
    end
    check("bounce_no_pulse", {31'd0, bus.cpu_en}, 32'd0);
    bus.push = 1'b1;
    expect_pulse();
    cycles(16);
    check("bounce_step_count", {24'd0, bus.step_count}, {24'd0, exp_steps});
    check("bounce_queue_empty", exp_q.size(), 32'd0);
    bus.push = 1'b0;
    cycles(12);

    // 256 press/release pairs: counter wraps back to zero.
    do_reset();
    cycles(5);
    for (int i = 0; i < 256; i++) begin
      bus.push = 1'b1;
      expect_pulse();
      cycles(12);
      bus.push = 1'b0;
      cycles(12);
      if (i == 254) begin
        check("wrap_count_254", {24'd0, bus.step_count}, {24'd0, exp_steps});
      end
    end
    check("wrap_step_count", {24'd0, bus.step_count}, 32'd0);
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // Press in free-run, switch to step mode while held: no pulse.
    bus.ena_switch = 1'b0;
    do_reset();
    cycles(5);
    check("freerun_cpu_en", {31'd0, bus.cpu_en}, 32'd1);
    bus.push = 1'b1;
    cycles(12);
    check("freerun_press_cpu_en", {31'd0, bus.cpu_en}, 32'd1);
    check("freerun_press_count", {24'd0, bus.step_count}, 32'd0);
    bus.ena_switch = 1'b1;
    cycles(2);
    check("mode_chg_before_mode", {31'd0, bus.step_mode}, 32'd0);
    check("mode_chg_before_en", {31'd0, bus.cpu_en}, 32'd1);
    cycles(1);
    check("mode_chg_after_mode", {31'd0, bus.step_mode}, 32'd1);
    check("mode_chg_after_en", {31'd0, bus.cpu_en}, 32'd0);
    cycles(12);
    bus.push = 1'b0;
    cycles(12);
    check("held_no_pulse_count", {24'd0, bus.step_count}, 32'd0);
    bus.push = 1'b1;
    expect_pulse();
    cycles(14);
    check("repress_step_count", {24'd0, bus.step_count}, {24'd0, exp_steps});
    check("repress_queue_empty", exp_q.size(), 32'd0);
    bus.push = 1'b0;
    cycles(12);

    // Reset with the debounce counter at D-1: press discarded, re-debounced.
    do_reset();
    cycles(5);
    bus.push = 1'b1;
    cycles(5);
    reset = 1'b0;
    exp_steps = 8'h00;
    cycles(1);
    check("midrst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    check("midrst_step_count", {24'd0, bus.step_count}, 32'd0);
    check("midrst_step_mode", {31'd0, bus.step_mode}, 32'd0);
    cycles(1);
    reset = 1'b1;
    expect_pulse();
    cycles(14);
    check("midrst_final_count", {24'd0, bus.step_count}, {24'd0, exp_steps});
    check("midrst_queue_empty", exp_q.size(), 32'd0);
    bus.push = 1'b0;
    cycles(12);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_step_clock_ctrl
